// File: rtl/msrv32_imem_responder_pkg.sv
// msrv32_pkg: shared encodings for the instruction-memory responder.
//   htrans_t      AHB-lite transfer type encoding
//   HRESP_*       AHB-lite response encoding
//   imem_state_t  responder FSM states
//   imem_hready / imem_hresp  decode of the bus handshake for a given state
package msrv32_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    IMEM_IDLE = 3'd0,
    IMEM_WAIT = 3'd1,
    IMEM_DATA = 3'd2,
    IMEM_ERR1 = 3'd3,
    IMEM_ERR2 = 3'd4
  } imem_state_t;

  // hready seen by the initiator while the FSM sits in the given state
  function automatic logic imem_hready(input imem_state_t st);
    logic rdy_s;
    case (st)
      IMEM_WAIT: rdy_s = 1'b0;
      IMEM_ERR1: rdy_s = 1'b0;
      default:   rdy_s = 1'b1;
    endcase
    return rdy_s;
  endfunction

  // hresp seen by the initiator while the FSM sits in the given state
  function automatic logic imem_hresp(input imem_state_t st);
    logic rsp_s;
    case (st)
      IMEM_ERR1: rsp_s = HRESP_ERROR;
      IMEM_ERR2: rsp_s = HRESP_ERROR;
      default:   rsp_s = HRESP_OKAY;
    endcase
    return rsp_s;
  endfunction

endpackage

// File: rtl/msrv32_imem_responder_if.sv
// Fetch-side AHB-lite bus between the core's fetch initiator and the
// instruction-memory responder.
//   master: drives hsel/htrans/haddr/hwrite, receives hrdata/hready/hresp
//   slave : the reverse
interface msrv32_imem_responder_if;
  logic        hsel_in;
  logic [1:0]  htrans_in;
  logic [31:0] haddr_in;
  logic        hwrite_in;
  logic [31:0] hrdata_out;
  logic        hready_out;
  logic        hresp_out;

  modport master (
    output hsel_in, htrans_in, haddr_in, hwrite_in,
    input  hrdata_out, hready_out, hresp_out
  );

  modport slave (
    input  hsel_in, htrans_in, haddr_in, hwrite_in,
    output hrdata_out, hready_out, hresp_out
  );
endinterface

// File: rtl/msrv32_imem_responder_array.sv
// msrv32_imem_array: word-wide instruction storage.
//   clk_in, rst_n_in     clock / async active-low reset (read register only)
//   rd_en_in, rd_addr_in synchronous read request
//   rd_data_out          registered read data, holds between reads
//   wr_en_in, wr_addr_in, wr_data_in  backdoor write port
// A read and a write to the same word on the same edge return the old word.
module msrv32_imem_array #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          AW          = 10,
  parameter logic [31:0] RESET_DATA  = 32'h0000_0013
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          rd_en_in,
  input  logic [AW-1:0] rd_addr_in,
  output logic [31:0]   rd_data_out,
  input  logic          wr_en_in,
  input  logic [AW-1:0] wr_addr_in,
  input  logic [31:0]   wr_data_in
);

  logic [31:0] mem_r [DEPTH_WORDS];
  logic [31:0] rd_data_r;

  // Storage write; contents survive reset
  always_ff @(posedge clk_in) begin
    if (wr_en_in) begin
      mem_r[wr_addr_in] <= wr_data_in;
    end
  end

  // Read register samples the pre-write word and holds between reads
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_data_r <= RESET_DATA;
    end else if (rd_en_in) begin
      rd_data_r <= mem_r[rd_addr_in];
    end
  end

  assign rd_data_out = rd_data_r;

endmodule

// File: rtl/msrv32_imem_responder.sv
// msrv32_imem_responder: AHB-lite instruction-memory responder for the
// fetch path, with configurable wait states and a backdoor preload port.
//   clk_in, rst_n_in   clock / async active-low reset
//   bus (slave)        hsel/htrans/haddr/hwrite in, hrdata/hready/hresp out
//   ld_en_in, ld_addr_in, ld_data_in  preload write into the array
module msrv32_imem_responder
  import msrv32_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] RESET_DATA  = 32'h0000_0013,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  msrv32_imem_responder_if.slave  bus,
  input  logic                    ld_en_in,
  input  logic [AW-1:0]           ld_addr_in,
  input  logic [31:0]             ld_data_in
);

  localparam bit          ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [2:0]  WAIT_LOAD = ZERO_WAIT ? 3'd0 : 3'(WAIT_STATES - 1);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  imem_state_t   state_r, state_s;
  logic [2:0]    wait_cnt_r, wait_cnt_s;
  logic [AW-1:0] addr_r, addr_s;
  logic          hready_r, hresp_r;
  logic          accept_s, err_s, rd_en_s;
  logic [AW-1:0] rd_addr_s, req_idx_s;

  // Qualify and classify the address phase; ignored while hready is low
  always_comb begin
    accept_s  = hready_r && bus.hsel_in &&
                ((bus.htrans_in == HTRANS_NONSEQ) || (bus.htrans_in == HTRANS_SEQ));
    err_s     = (bus.haddr_in[1:0] != 2'b00) || bus.hwrite_in ||
                (bus.haddr_in[31:2] >= DEPTH_LIM);
    req_idx_s = bus.haddr_in[AW+1:2];
  end

  // Next-state, wait counter and array read request
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    addr_s     = addr_r;
    rd_en_s    = 1'b0;
    rd_addr_s  = addr_r;
    case (state_r)
      IMEM_WAIT: begin
        if (wait_cnt_r == 3'd0) begin
          state_s = IMEM_DATA;
          rd_en_s = 1'b1;
        end else begin
          wait_cnt_s = wait_cnt_r - 3'd1;
        end
      end
      IMEM_ERR1: begin
        state_s = IMEM_ERR2;
      end
      IMEM_IDLE, IMEM_DATA, IMEM_ERR2: begin
        if (!accept_s) begin
          state_s = IMEM_IDLE;
        end else if (err_s) begin
          state_s = IMEM_ERR1;
        end else if (ZERO_WAIT) begin
          // Read issued on the sampling edge so data appears next cycle
          state_s   = IMEM_DATA;
          rd_en_s   = 1'b1;
          rd_addr_s = req_idx_s;
        end else begin
          state_s    = IMEM_WAIT;
          wait_cnt_s = WAIT_LOAD;
          addr_s     = req_idx_s;
        end
      end
      default: begin
        state_s = IMEM_IDLE;
      end
    endcase
  end

  // State, counter, captured address and registered handshake outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r    <= IMEM_IDLE;
      wait_cnt_r <= 3'd0;
      addr_r     <= '0;
      hready_r   <= 1'b1;
      hresp_r    <= HRESP_OKAY;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      addr_r     <= addr_s;
      hready_r   <= imem_hready(state_s);
      hresp_r    <= imem_hresp(state_s);
    end
  end

  msrv32_imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW),
    .RESET_DATA  (RESET_DATA)
  ) u_array (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .rd_en_in    (rd_en_s),
    .rd_addr_in  (rd_addr_s),
    .rd_data_out (bus.hrdata_out),
    .wr_en_in    (ld_en_in),
    .wr_addr_in  (ld_addr_in),
    .wr_data_in  (ld_data_in)
  );

  assign bus.hready_out = hready_r;
  assign bus.hresp_out  = hresp_r;

endmodule

// File: tb/tb_msrv32_imem_responder.sv
// Directed bench: dut_a runs with two wait states, dut_b with none; both
// share the preload port and a 16-word array.
module tb_msrv32_imem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = 4'd0;
  logic [31:0] ld_data = 32'd0;
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  msrv32_imem_responder_if bus_a ();
  msrv32_imem_responder_if bus_b ();

  msrv32_imem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(2), .RESET_DATA(32'h0000_0013)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .bus(bus_a),
    .ld_en_in(ld_en), .ld_addr_in(ld_addr), .ld_data_in(ld_data));

  msrv32_imem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0), .RESET_DATA(32'h0000_0013)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .bus(bus_b),
    .ld_en_in(ld_en), .ld_addr_in(ld_addr), .ld_data_in(ld_data));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic sel, input logic [1:0] tr, input logic [31:0] ad, input logic wr);
    bus_a.hsel_in = sel; bus_a.htrans_in = tr; bus_a.haddr_in = ad; bus_a.hwrite_in = wr;
  endtask

  task automatic drive_b(input logic sel, input logic [1:0] tr, input logic [31:0] ad, input logic wr);
    bus_b.hsel_in = sel; bus_b.htrans_in = tr; bus_b.haddr_in = ad; bus_b.hwrite_in = wr;
  endtask

  initial begin
    drive_a(1'b0, 2'b00, 32'd0, 1'b0);
    drive_b(1'b0, 2'b00, 32'd0, 1'b0);

    // Reset values
    step(); step();
    chk("rst_a_hready", 32'(bus_a.hready_out), 32'd1);
    chk("rst_a_hresp",  32'(bus_a.hresp_out),  32'd0);
    chk("rst_a_hrdata", bus_a.hrdata_out, 32'h0000_0013);
    chk("rst_b_hrdata", bus_b.hrdata_out, 32'h0000_0013);
    rst_n = 1'b1;

    // Preload words 4, 0, 1
    ld_en = 1'b1; ld_addr = 4'd4; ld_data = 32'h00A0_0093; step();
    ld_addr = 4'd0; ld_data = 32'h1111_1111; step();
    ld_addr = 4'd1; ld_data = 32'h2222_2222; step();
    ld_en = 1'b0;

    // Two-wait-state fetch of 0x10
    drive_a(1'b1, 2'b10, 32'h10, 1'b0); step();
    chk("ws2_w1_hready", 32'(bus_a.hready_out), 32'd0);
    drive_a(1'b0, 2'b00, 32'h0, 1'b0); step();
    chk("ws2_w2_hready", 32'(bus_a.hready_out), 32'd0);
    step();
    chk("ws2_data_hready", 32'(bus_a.hready_out), 32'd1);
    chk("ws2_data_hresp",  32'(bus_a.hresp_out),  32'd0);
    chk("ws2_data_hrdata", bus_a.hrdata_out, 32'h00A0_0093);
    step();

    // Inputs changed while stalled are ignored
    drive_a(1'b1, 2'b10, 32'h0, 1'b0); step();
    chk("stall_w1_hrdata", bus_a.hrdata_out, 32'h00A0_0093);
    drive_a(1'b1, 2'b10, 32'h2, 1'b0); step();
    step();
    chk("stall_data_hready", 32'(bus_a.hready_out), 32'd1);
    chk("stall_data_hresp",  32'(bus_a.hresp_out),  32'd0);
    chk("stall_data_hrdata", bus_a.hrdata_out, 32'h1111_1111);
    drive_a(1'b0, 2'b00, 32'h0, 1'b0); step();

    // Misaligned address: two-cycle error, data held
    drive_a(1'b1, 2'b10, 32'h2, 1'b0); step();
    chk("mis_err1_hready", 32'(bus_a.hready_out), 32'd0);
    chk("mis_err1_hresp",  32'(bus_a.hresp_out),  32'd1);
    chk("mis_err1_hrdata", bus_a.hrdata_out, 32'h1111_1111);
    drive_a(1'b0, 2'b00, 32'h0, 1'b0); step();
    chk("mis_err2_hready", 32'(bus_a.hready_out), 32'd1);
    chk("mis_err2_hresp",  32'(bus_a.hresp_out),  32'd1);
    chk("mis_err2_hrdata", bus_a.hrdata_out, 32'h1111_1111);
    step();
    chk("mis_idle_hresp", 32'(bus_a.hresp_out), 32'd0);

    // Out-of-range, then a write accepted back-to-back from ERR2
    drive_a(1'b1, 2'b10, 32'd64, 1'b0); step();
    chk("oor_err1_hready", 32'(bus_a.hready_out), 32'd0);
    chk("oor_err1_hresp",  32'(bus_a.hresp_out),  32'd1);
    step();
    chk("oor_err2_hready", 32'(bus_a.hready_out), 32'd1);
    chk("oor_err2_hresp",  32'(bus_a.hresp_out),  32'd1);
    drive_a(1'b1, 2'b10, 32'h4, 1'b1); step();
    chk("wr_err1_hready", 32'(bus_a.hready_out), 32'd0);
    chk("wr_err1_hresp",  32'(bus_a.hresp_out),  32'd1);
    drive_a(1'b0, 2'b00, 32'h0, 1'b0); step();
    chk("wr_err2_hready", 32'(bus_a.hready_out), 32'd1);
    chk("wr_err2_hresp",  32'(bus_a.hresp_out),  32'd1);
    step();
    chk("wr_idle_hresp", 32'(bus_a.hresp_out), 32'd0);

    // Reset asserted during WAIT aborts the fetch immediately
    drive_a(1'b1, 2'b10, 32'h10, 1'b0); step();
    chk("abort_wait_hready", 32'(bus_a.hready_out), 32'd0);
    drive_a(1'b0, 2'b00, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_hready", 32'(bus_a.hready_out), 32'd1);
    chk("abort_hresp",  32'(bus_a.hresp_out),  32'd0);
    chk("abort_hrdata", bus_a.hrdata_out, 32'h0000_0013);
    #2 rst_n = 1'b1;
    step();
    drive_a(1'b1, 2'b10, 32'h4, 1'b0); step();
    chk("post_w1_hready", 32'(bus_a.hready_out), 32'd0);
    drive_a(1'b0, 2'b00, 32'h0, 1'b0); step();
    chk("post_w2_hready", 32'(bus_a.hready_out), 32'd0);
    step();
    chk("post_data_hready", 32'(bus_a.hready_out), 32'd1);
    chk("post_data_hrdata", bus_a.hrdata_out, 32'h2222_2222);

    // Zero-wait back-to-back NONSEQ 0x0, SEQ 0x4
    drive_b(1'b1, 2'b10, 32'h0, 1'b0); step();
    chk("b2b_d0_hready", 32'(bus_b.hready_out), 32'd1);
    chk("b2b_d0_hresp",  32'(bus_b.hresp_out),  32'd0);
    chk("b2b_d0_hrdata", bus_b.hrdata_out, 32'h1111_1111);
    drive_b(1'b1, 2'b11, 32'h4, 1'b0); step();
    chk("b2b_d1_hready", 32'(bus_b.hready_out), 32'd1);
    chk("b2b_d1_hrdata", bus_b.hrdata_out, 32'h2222_2222);
    drive_b(1'b0, 2'b00, 32'h0, 1'b0); step();

    // Preload colliding with the DATA-entry read returns the old word
    drive_b(1'b1, 2'b10, 32'h10, 1'b0);
    ld_en = 1'b1; ld_addr = 4'd4; ld_data = 32'hDEAD_BEEF;
    step();
    ld_en = 1'b0;
    chk("col_old_hrdata", bus_b.hrdata_out, 32'h00A0_0093);
    step();
    chk("col_new_hrdata", bus_b.hrdata_out, 32'hDEAD_BEEF);
    drive_b(1'b0, 2'b00, 32'h0, 1'b0); step();
    chk("col_idle_hready", 32'(bus_b.hready_out), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
